// File: rtl/deser_pkg.sv
// Shared types and constants for the parametrised deserializer.
// Frame FSM states, error codes and parity mode encodings.
package deser_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      PARITY,
      STOP,
      BREAK
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_PARITY  = 2'd1,
      ERR_FRAMING = 2'd2,
      ERR_OVERRUN = 2'd3
   } err_code_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   // x is the XOR of all data bits and the received parity bit
   function automatic logic parity_bad(input logic x, input int mode);
      return (mode == PAR_EVEN && x) || (mode == PAR_ODD && !x);
   endfunction

endpackage

// File: rtl/deser_hold_reg.sv
// Output holding register with valid/ready handshake.
// Flags an overrun when a word arrives while the held one stays put.
module deser_hold_reg #(
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              eob_i,
   input  logic              ready_i,
   output logic [DATA_W-1:0] data_o,
   output logic              eob_o,
   output logic              valid_o,
   output logic              loaded_o,
   output logic              overrun_o
);

   logic accept;

   // a word being handed off on this edge frees the slot
   assign accept    = !valid_o || ready_i;
   assign loaded_o  = load_i && accept;
   assign overrun_o = load_i && !accept;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_o  <= '0;
         eob_o   <= 1'b0;
         valid_o <= 1'b0;
      end else if (loaded_o) begin
         data_o  <= data_i;
         eob_o   <= eob_i;
         valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
         valid_o <= 1'b0;
      end
   end

endmodule

// File: rtl/param_deserializer.sv
// Serial-to-parallel frame receiver with parity, block grouping
// and a valid/ready output port with error pulses.
module param_deserializer #(
   parameter int DATA_W    = 8,
   parameter int PARITY    = 1,
   parameter int BLOCK_LEN = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              inputdata_i,
   output logic [DATA_W-1:0] outputdata_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              eob_o,
   output logic              err_o,
   output logic [1:0]        err_code_o
);
   import deser_pkg::*;

   localparam int BW = $clog2(DATA_W);
   localparam int CW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
   localparam logic [CW-1:0] LAST_WORD = CW'(BLOCK_LEN - 1);

   state_e            state_q, state_d;
   logic [BW-1:0]     bit_q;
   logic [DATA_W-1:0] shift_q;
   logic              par_q;
   logic              shift_en, par_en, stop_en;
   err_code_e         frame_code;
   logic              pend_q;
   err_code_e         pend_code_q;
   logic [CW-1:0]     cnt_q;
   logic              load_req, loaded, overrun, is_last;
   logic              err_q;
   err_code_e         err_code_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (!inputdata_i) state_d = DATA;
         DATA:  if (bit_q == LAST_BIT)
                   state_d = (PARITY == PAR_NONE) ? STOP : deser_pkg::PARITY;
         deser_pkg::PARITY: state_d = STOP;
         STOP:  state_d = inputdata_i ? IDLE : BREAK;
         BREAK: if (inputdata_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      shift_en = 1'b0;
      par_en   = 1'b0;
      stop_en  = 1'b0;
      unique case (1'b1)
         state_q == DATA:              shift_en = 1'b1;
         state_q == deser_pkg::PARITY: par_en   = 1'b1;
         state_q == STOP:              stop_en  = 1'b1;
         default: ;
      endcase
   end

   // framing outranks parity; both judged on the stop-bit edge
   always_comb begin
      frame_code = ERR_NONE;
      if (!inputdata_i)
         frame_code = ERR_FRAMING;
      else if (parity_bad((^shift_q) ^ par_q, PARITY))
         frame_code = ERR_PARITY;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bit_q       <= '0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         pend_q      <= 1'b0;
         pend_code_q <= ERR_NONE;
      end else begin
         if (state_q == IDLE) bit_q <= '0;
         else if (shift_en)   bit_q <= bit_q + 1'b1;
         if (shift_en) shift_q <= {inputdata_i, shift_q[DATA_W-1:1]};
         if (par_en)   par_q   <= inputdata_i;
         pend_q <= stop_en;
         if (stop_en) pend_code_q <= frame_code;
      end
   end

   // shift_q is untouched until the next frame's first data bit
   assign load_req = pend_q && (pend_code_q == ERR_NONE);
   assign is_last  = (cnt_q == LAST_WORD);

   deser_hold_reg #(
      .DATA_W (DATA_W)
   ) u_hold (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load_i    (load_req),
      .data_i    (shift_q),
      .eob_i     (is_last),
      .ready_i   (ready_i),
      .data_o    (outputdata_o),
      .eob_o     (eob_o),
      .valid_o   (valid_o),
      .loaded_o  (loaded),
      .overrun_o (overrun)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i)       cnt_q <= '0;
      else if (loaded) cnt_q <= is_last ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         err_q <= pend_q && ((pend_code_q != ERR_NONE) || overrun);
         if (!pend_q)                    err_code_q <= ERR_NONE;
         else if (pend_code_q != ERR_NONE) err_code_q <= pend_code_q;
         else if (overrun)               err_code_q <= ERR_OVERRUN;
         else                            err_code_q <= ERR_NONE;
      end
   end

   assign err_o      = err_q;
   assign err_code_o = err_code_q;

endmodule

// File: tb/tb_param_deserializer.sv
// Directed bench for param_deserializer: parity 1 main instance,
// plus parity-none and parity-odd instances for latency checks.
module tb_param_deserializer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ready = 1'b1;
   logic       line = 1'b1;
   int         lsel = 1;
   logic       line0, line1, line2;

   logic [7:0] data0, data1, data2;
   logic       valid0, valid1, valid2;
   logic       eob0, eob1, eob2;
   logic       err0, err1, err2;
   logic [1:0] code0, code1, code2;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] wq[$];
   logic       eq[$];
   logic [1:0] cq[$];

   always #5 clk = ~clk;

   assign line0 = (lsel == 0) ? line : 1'b1;
   assign line1 = (lsel == 1) ? line : 1'b1;
   assign line2 = (lsel == 2) ? line : 1'b1;

   param_deserializer #(.DATA_W(8), .PARITY(1), .BLOCK_LEN(4)) dut (
      .clk_i(clk), .rst_i(rst), .inputdata_i(line1),
      .outputdata_o(data1), .valid_o(valid1), .ready_i(ready),
      .eob_o(eob1), .err_o(err1), .err_code_o(code1));

   param_deserializer #(.DATA_W(8), .PARITY(0), .BLOCK_LEN(4)) dut0 (
      .clk_i(clk), .rst_i(rst), .inputdata_i(line0),
      .outputdata_o(data0), .valid_o(valid0), .ready_i(ready),
      .eob_o(eob0), .err_o(err0), .err_code_o(code0));

   param_deserializer #(.DATA_W(8), .PARITY(2), .BLOCK_LEN(4)) dut2 (
      .clk_i(clk), .rst_i(rst), .inputdata_i(line2),
      .outputdata_o(data2), .valid_o(valid2), .ready_i(ready),
      .eob_o(eob2), .err_o(err2), .err_code_o(code2));

   // inputs change at posedge+1, so negedge sees the handshake inputs
   always @(negedge clk) begin
      if (valid1 && ready) begin
         wq.push_back(data1);
         eq.push_back(eob1);
      end
      if (err1) cq.push_back(code1);
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      line = b;
      tick();
   endtask

   task automatic send_frame(input logic [7:0] d, input int mode,
                             input bit bad_par, input logic stop);
      logic p;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      if (mode != 0) begin
         p = ^d;
         if (mode == 2) p = ~p;
         if (bad_par)   p = ~p;
         send_bit(p);
      end
      send_bit(stop);
   endtask

   task automatic idle(input int n);
      line = 1'b1;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      line = 1'b1;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic clr();
      wq.delete();
      eq.delete();
      cq.delete();
   endtask

   initial begin
      repeat (3) tick();
      check("in_reset", {valid1, eob1, err1, code1, data1}, 0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_quiet", {valid1, eob1, err1, code1, data1}, 0);
      end

      clr();
      send_frame(8'hA5, 1, 0, 1'b1);
      check("a5_early", valid1, 0);
      tick();
      check("a5_valid", valid1, 1);
      check("a5_data", data1, 8'hA5);
      check("a5_eob", eob1, 0);
      tick();
      check("a5_drop", valid1, 0);

      idle(2);
      clr();
      send_frame(8'hA5, 1, 1, 1'b1);
      idle(4);
      check("par_errs", cq.size(), 1);
      check("par_code", (cq.size() > 0) ? cq[0] : 2'd0, 1);
      check("par_words", wq.size(), 0);

      clr();
      send_frame(8'h3C, 1, 0, 1'b0);
      repeat (5) send_bit(1'b0);
      idle(20);
      check("frm_errs", cq.size(), 1);
      check("frm_code", (cq.size() > 0) ? cq[0] : 2'd0, 2);
      check("frm_words", wq.size(), 0);

      do_reset();
      clr();
      for (int k = 1; k <= 5; k++) send_frame(8'(k), 1, 0, 1'b1);
      idle(3);
      check("blk_count", wq.size(), 5);
      check("blk_errs", cq.size(), 0);
      for (int i = 0; i < 5 && i < wq.size(); i++) begin
         check($sformatf("blk_data%0d", i), wq[i], i + 1);
         check($sformatf("blk_eob%0d", i), eq[i], (i == 3) ? 1 : 0);
      end

      do_reset();
      clr();
      ready = 1'b0;
      send_frame(8'h11, 1, 0, 1'b1);
      idle(2);
      check("ovr_hold", {valid1, data1}, {1'b1, 8'h11});
      send_frame(8'h22, 1, 0, 1'b1);
      idle(2);
      check("ovr_errs", cq.size(), 1);
      check("ovr_code", (cq.size() > 0) ? cq[0] : 2'd0, 3);
      check("ovr_kept", {valid1, data1, eob1}, {1'b1, 8'h11, 1'b0});
      ready = 1'b1;
      tick();
      tick();
      check("ovr_words", wq.size(), 1);
      check("ovr_data", (wq.size() > 0) ? wq[0] : 8'h0, 8'h11);
      send_frame(8'h33, 1, 0, 1'b1);
      send_frame(8'h44, 1, 0, 1'b1);
      send_frame(8'h55, 1, 0, 1'b1);
      idle(3);
      check("ovr_blk_n", wq.size(), 4);
      check("ovr_eob44", (wq.size() > 2) ? eq[2] : 1'b1, 0);
      check("ovr_eob55", (wq.size() > 3) ? eq[3] : 1'b0, 1);

      send_frame(8'h66, 1, 0, 1'b1);
      send_frame(8'h77, 1, 0, 1'b1);
      send_frame(8'h88, 1, 0, 1'b1);
      idle(3);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      do_reset();
      check("rst_mid", {valid1, eob1, err1, code1, data1}, 0);
      idle(2);
      clr();
      send_frame(8'h5A, 1, 0, 1'b1);
      idle(3);
      check("rst_words", wq.size(), 1);
      check("rst_data", (wq.size() > 0) ? wq[0] : 8'h0, 8'h5A);
      check("rst_eob", (wq.size() > 0) ? eq[0] : 1'b1, 0);
      check("rst_errs", cq.size(), 0);

      do_reset();
      lsel = 0;
      send_frame(8'hFF, 0, 0, 1'b1);
      check("p0_early", valid0, 0);
      tick();
      check("p0_valid", valid0, 1);
      check("p0_data", data0, 8'hFF);
      idle(3);
      lsel = 2;
      send_frame(8'hFF, 2, 0, 1'b1);
      check("p2_early", valid2, 0);
      tick();
      check("p2_valid", valid2, 1);
      check("p2_data", data2, 8'hFF);
      check("p2_err", err2, 0);
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
